// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
//   producers. One byte is accepted from the winning requester. That byte is
//   presented to the transmitter with a single-cycle send strobe. The next
//   grant is held off until the transmitter reports the frame as done.
//
//   Optional feature macro: UART_TX_ARB_WATCHDOG_EN
//     When defined, a TIMEOUT_W-bit watchdog aborts a frame that never
//     completes. It pulses timeout_o and drops the byte.
//
// Ports
//   clk_i        clock (shared with the transmitter)
//   rst_i        synchronous active-high reset
//   en_i         allow new grants (an in-flight frame always completes)
//   req_valid_i  per-requester byte valid
//   req_data_i   packed bytes, requester i at [i*DATA_UART +: DATA_UART]
//   req_ready_o  one-hot accept strobe (IDLE only)
//   grant_o      one-hot owner of the current frame, zero when idle
//   tx_data_o    byte to transmitter tx_data_i (held after the frame)
//   tx_send_o    one-cycle send strobe to transmitter tx_send_i
//   tx_busy_i    transmitter busy_o
//   tx_ready_i   transmitter tx_ready_o (one-cycle done pulse)
//   active_o     high whenever the scheduler is not idle
//   timeout_o    one-cycle watchdog pulse (tied low without the macro)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_UART = 8,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_UART-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [DATA_UART-1:0]           tx_data_o,
  output logic                           tx_send_o,
  input  logic                           tx_busy_i,
  input  logic                           tx_ready_i,
  output logic                           active_o,
  output logic                           timeout_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    r_grant;
  logic [DATA_UART-1:0]  r_tx_data;

  logic                  w_found;
  logic                  w_accept;
  logic [PTR_W-1:0]      w_winner;
  logic [NUM_REQ-1:0]    w_winner_oh;
  logic [DATA_UART-1:0]  w_bytes [NUM_REQ];

`ifdef UART_TX_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0]  r_wd;
  logic                  w_timeout;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data_i[g*DATA_UART +: DATA_UART];
  end

  // Rotating priority: the first pass covers indices at or above the pointer.
  // The second pass only runs when the first found nothing, so it naturally
  // covers the wrapped indices below the pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (PTR_W'(i) >= r_ptr) && req_valid_i[PTR_W'(i)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[PTR_W'(i)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(i);
      end
    end
  end

  assign w_winner_oh = NUM_REQ'(1) << w_winner;
  assign w_accept    = (r_state == ST_IDLE) && !rst_i && en_i && !tx_busy_i && w_found;
  assign req_ready_o = w_accept ? w_winner_oh : '0;

  always_comb begin
    w_state_nxt = r_state;
`ifdef UART_TX_ARB_WATCHDOG_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_IDLE:      if (w_accept) w_state_nxt = ST_SEND;
      ST_SEND:      w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        // A done pulse may arrive before busy was ever observed.
        if (tx_ready_i)     w_state_nxt = ST_IDLE;
        else if (tx_busy_i) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (tx_ready_i) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
`ifdef UART_TX_ARB_WATCHDOG_EN
    // A genuine done in the same cycle takes precedence over the timeout.
    if (((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) &&
        (r_wd == '1) && !tx_ready_i && !rst_i) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tx_data <= w_bytes[w_winner];
        r_grant   <= w_winner_oh;
        r_ptr     <= (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
      end else if (w_state_nxt == ST_IDLE) begin
        r_grant <= '0;
      end
    end
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept) begin
      r_wd <= '0;
    end else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) begin
      r_wd <= r_wd + TIMEOUT_W'(1);
    end
  end
  assign timeout_o = w_timeout;
`else
  logic [TIMEOUT_W-1:0] w_unused_wd;
  assign w_unused_wd = '0;
  assign timeout_o   = 1'b0;
`endif

  assign grant_o   = r_grant;
  assign tx_data_o = r_tx_data;
  assign tx_send_o = (r_state == ST_SEND);
  assign active_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter. The bench plays both the requesters and the
//   UART transmitter (busy/ready handshake). The expected winner of every
//   arbitration comes from a round-robin pointer model over the requester
//   valids. With UART_TX_ARB_WATCHDOG_EN defined, the watchdog abort is
//   also exercised (TIMEOUT_W = 4).
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, en, tx_busy, tx_ready;
  logic [N-1:0]   req_valid, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   tx_data;
  logic           tx_send, active, timeout;

  int             checks   = 0;
  int             failures = 0;
  int             m_ptr    = 0;
  logic [W-1:0]   m_byte [N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_UART(W), .TIMEOUT_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_data_o   (tx_data),
    .tx_send_o   (tx_send),
    .tx_busy_i   (tx_busy),
    .tx_ready_i  (tx_ready),
    .active_o    (active),
    .timeout_o   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] b);
    req_valid[i]       = 1'b1;
    req_data[i*W +: W] = b;
    m_byte[i]          = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    next_cycle();
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // Reference arbitration: first valid at or after the pointer, with wrap.
  function automatic int pick();
    if (!en || tx_busy || req_valid == '0) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Samples an IDLE cycle; returns the model's winner (-1 for none).
  task automatic idle_cycle(output int w);
    @(negedge clk);
    w = pick();
    check_eq("req_ready", 32'(req_ready), (w < 0) ? 0 : (1 << w));
    check_eq("idle_grant", 32'(grant), 0);
    check_eq("idle_active", 32'(active), 0);
  endtask

  // Follows an accepted byte through SEND, blen busy cycles and the done pulse.
  task automatic frame(input int w, input int blen, input bit keep, input bit drop_en);
    logic [W-1:0] b;
    logic [N-1:0] oh;
    b     = m_byte[w];
    oh    = N'(1) << w;
    m_ptr = (w + 1) % N;
    next_cycle();
    if (!keep) req_valid[w] = 1'b0;
    if (drop_en) en = 1'b0;
    @(negedge clk);
    check_eq("send_pulse", 32'(tx_send), 1);
    check_eq("tx_data", 32'(tx_data), 32'(b));
    check_eq("grant_send", 32'(grant), 32'(oh));
    check_eq("send_active", 32'(active), 1);
    for (int c = 0; c < blen; c++) begin
      next_cycle();
      tx_busy = 1'b1;
      @(negedge clk);
      check_eq("send_once", 32'(tx_send), 0);
      check_eq("grant_hold", 32'(grant), 32'(oh));
      check_eq("busy_no_ready", 32'(req_ready), 0);
      check_eq("no_timeout", 32'(timeout), 0);
    end
    next_cycle();
    tx_busy  = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    check_eq("grant_done", 32'(grant), 32'(oh));
    check_eq("done_no_ready", 32'(req_ready), 0);
    next_cycle();
    tx_ready = 1'b0;
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    en        = 1'b1;
    tx_busy   = 1'b1;
    tx_ready  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    set_req(2, 8'hA5);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_data", 32'(tx_data), 0);
    check_eq("rst_send", 32'(tx_send), 0);
    check_eq("rst_active", 32'(active), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    next_cycle();
    rst = 1'b0;

    // Transmitter still busy out of its own reset: no grant.
    repeat (3) begin
      idle_cycle(w);
      next_cycle();
    end
    tx_busy = 1'b0;
    idle_cycle(w);
    check_eq("single_ready", 32'(req_ready), 32'h4);
    if (w >= 0) frame(w, 5, 1'b0, 1'b0);

    // All requesters continuously valid: strict rotation, 2-cycle gap.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      idle_cycle(w);
      check_eq("rr_order", 32'(req_ready), 32'(1) << (k % N));
      if (w >= 0) frame(w, 3 + k, 1'b1, 1'b0);
    end

    // Enable gating, and en dropped mid-frame.
    do_reset();
    en = 1'b0;
    set_req(0, 8'h3C);
    set_req(2, 8'h5A);
    repeat (3) begin
      idle_cycle(w);
      next_cycle();
    end
    en = 1'b1;
    idle_cycle(w);
    check_eq("en_first", 32'(req_ready), 32'h1);
    if (w >= 0) frame(w, 4, 1'b0, 1'b1);
    idle_cycle(w);
    next_cycle();
    en = 1'b1;
    idle_cycle(w);
    if (w >= 0) frame(w, 2, 1'b0, 1'b0);

    // Reset while waiting for done.
    set_req(1, 8'h77);
    idle_cycle(w);
    if (w >= 0) begin
      next_cycle();
      req_valid[w] = 1'b0;
      next_cycle();
      tx_busy = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst   = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      check_eq("mid_rst_grant", 32'(grant), 0);
      check_eq("mid_rst_active", 32'(active), 0);
      check_eq("mid_rst_send", 32'(tx_send), 0);
      check_eq("mid_rst_data", 32'(tx_data), 0);
      check_eq("mid_rst_ready", 32'(req_ready), 0);
      next_cycle();
      tx_busy = 1'b0;
      set_req(3, 8'h99);
      set_req(2, 8'h22);
      idle_cycle(w);
      check_eq("post_rst_lowest", 32'(req_ready), 32'h4);
      if (w >= 0) frame(w, 1, 1'b0, 1'b0);
    end

    // Randomized traffic against the pointer model.
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 8'($urandom));
      en      = ($urandom_range(0, 9) != 0);
      tx_busy = ($urandom_range(0, 9) == 0);
      idle_cycle(w);
      if (w >= 0) frame(w, $urandom_range(0, 10), 1'b0, 1'($urandom_range(0, 1)));
      else next_cycle();
    end
    tx_busy = 1'b0;
    en      = 1'b1;

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Transmitter never completes: abort when the 4-bit watchdog hits 15.
    do_reset();
    set_req(1, 8'hE1);
    idle_cycle(w);
    check_eq("wd_accept", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid[1] = 1'b0;
    m_ptr        = 2;
    @(negedge clk);
    check_eq("wd_send", 32'(tx_send), 1);
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      tx_busy = 1'b1;
      @(negedge clk);
      check_eq("wd_quiet", 32'(timeout), 0);
      check_eq("wd_grant", 32'(grant), 32'h2);
    end
    next_cycle();
    @(negedge clk);
    check_eq("wd_pulse", 32'(timeout), 1);
    next_cycle();
    @(negedge clk);
    check_eq("wd_pulse_end", 32'(timeout), 0);
    check_eq("wd_grant_clr", 32'(grant), 0);
    check_eq("wd_idle", 32'(active), 0);
    next_cycle();
    tx_busy = 1'b0;
    set_req(3, 8'h3E);
    idle_cycle(w);
    check_eq("wd_next_accept", 32'(req_ready), 32'h8);
    if (w >= 0) frame(w, 2, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
